// File: rtl/dsp_pkg.sv
// Shared DSP types for the fft_32 datapath and its frame scheduler.
// Holds the fft_32 input control bundle, scheduler states and frame/tag sizes.
package dsp_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] data_index;
        logic       last;
        logic       reverse;
        logic [7:0] tag;
    } fft32_control_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        READ,
        GAP
    } fft32_sched_state_t;

    localparam int FFT32_FRAME_LENGTH = 32;
    localparam int FFT32_TAG_WIDTH    = 8;

endpackage

// File: rtl/fft_32_rr_arbiter.sv
// Round-robin frame arbiter for fft_32_frame_scheduler.
// Ports: clk/rst (async, active high), req (ready vector), grant (strobe that
// commits the current winner), winner (index), any (some request present).
// FFT_32_FRAME_SCHEDULER_PRIORITY_EN: requester 0 wins over everyone else,
// round-robin among requesters 1..N-1 only.
module fft_32_rr_arbiter
    import dsp_pkg::*;
#(
    parameter int  NUM_REQUESTERS = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQUESTERS-1:0] req,
    input  logic                      grant,
    output logic [ID_WIDTH-1:0]       winner,
    output logic                      any
);

    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] cand;

    // Search order starts one past the last winner and wraps naturally
    // because N is a power of two; i == N lands back on ptr itself.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQUESTERS; i++) begin
            cand = ptr + ID_WIDTH'(i);
`ifdef FFT_32_FRAME_SCHEDULER_PRIORITY_EN
            if (!any && req[cand] && (cand != '0)) begin
                winner = cand;
                any    = 1'b1;
            end
`else
            if (!any && req[cand]) begin
                winner = cand;
                any    = 1'b1;
            end
`endif
        end
`ifdef FFT_32_FRAME_SCHEDULER_PRIORITY_EN
        if (req[0]) begin
            winner = '0;
            any    = 1'b1;
        end
`endif
    end

    // Pointer resets to N-1 so requester 0 is first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= ID_WIDTH'(NUM_REQUESTERS - 1);
        end else if (grant && any) begin
`ifdef FFT_32_FRAME_SCHEDULER_PRIORITY_EN
            // Priority wins by requester 0 leave the 1..N-1 rotation alone.
            if (winner != '0) begin
                ptr <= winner;
            end
`else
            ptr <= winner;
`endif
        end
    end

endmodule

// File: rtl/fft_32_frame_scheduler.sv
// Shares one fft_32 between NUM_REQUESTERS frame buffers, one whole frame
// at a time, driving Input_control/Input_i/Input_q with index, last, reverse
// and an owner tag {requester id, per-requester frame counter}.
// Ports: Clk, Rst (async, active high); Req_ready/Req_reverse/Req_done
// requester handshake; Rd_addr/Rd_en/Rd_data_i/Rd_data_q buffer read port
// (1-cycle latency); Output_control/Output_i/Output_q to fft_32;
// Frame_count total frames issued.
// FFT_32_FRAME_SCHEDULER_PRIORITY_EN gives requester 0 strict priority.
module fft_32_frame_scheduler
    import dsp_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int FRAME_GAP      = 0
) (
    input  logic                                 Clk,
    input  logic                                 Rst,
    input  logic [NUM_REQUESTERS-1:0]            Req_ready,
    input  logic [NUM_REQUESTERS-1:0]            Req_reverse,
    output logic [NUM_REQUESTERS-1:0]            Req_done,
    output logic [4:0]                           Rd_addr,
    output logic [NUM_REQUESTERS-1:0]            Rd_en,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] Rd_data_i,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] Rd_data_q,
    output fft32_control_t                       Output_control,
    output logic signed [DATA_WIDTH-1:0]         Output_i,
    output logic signed [DATA_WIDTH-1:0]         Output_q,
    output logic [31:0]                          Frame_count
);

    localparam int ID_W  = $clog2(NUM_REQUESTERS);
    localparam int CTR_W = FFT32_TAG_WIDTH - ID_W;
    localparam logic [4:0] LAST_IDX = 5'(FFT32_FRAME_LENGTH - 1);
    localparam logic [4:0] DONE_IDX = 5'(FFT32_FRAME_LENGTH - 2);

    fft32_sched_state_t state;

    logic [ID_W-1:0]  arb_win;
    logic             arb_any;
    logic             grant_stb;
    logic [ID_W-1:0]  win_q;
    logic             rev_q;
    logic [7:0]       tag_q;
    logic [7:0]       gap_cnt;
    logic [CTR_W-1:0] frame_ctr [NUM_REQUESTERS];

    logic             v1;
    logic [4:0]       idx1;
    logic             last1;
    logic [DATA_WIDTH-1:0] mux_i;
    logic [DATA_WIDTH-1:0] mux_q;

    assign grant_stb = (state == GRANT);

    fft_32_rr_arbiter #(
        .NUM_REQUESTERS(NUM_REQUESTERS)
    ) u_arb (
        .clk   (Clk),
        .rst   (Rst),
        .req   (Req_ready),
        .grant (grant_stb),
        .winner(arb_win),
        .any   (arb_any)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            Rd_addr  <= '0;
            Rd_en    <= '0;
            Req_done <= '0;
            win_q    <= '0;
            rev_q    <= 1'b0;
            tag_q    <= '0;
            gap_cnt  <= '0;
            for (int n = 0; n < NUM_REQUESTERS; n++) begin
                frame_ctr[n] <= '0;
            end
        end else begin
            Req_done <= '0;
            unique case (state)
                IDLE: begin
                    if (|Req_ready) begin
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // Ready may have dropped since IDLE; go back and wait.
                    if (arb_any) begin
                        win_q   <= arb_win;
                        rev_q   <= Req_reverse[arb_win];
                        tag_q   <= {arb_win, frame_ctr[arb_win]};
                        Rd_en   <= NUM_REQUESTERS'(1) << arb_win;
                        Rd_addr <= '0;
                        state   <= READ;
                    end else begin
                        state <= IDLE;
                    end
                end
                READ: begin
                    // Registered, so set one address early to line up
                    // the pulse with Rd_addr == 31.
                    if (Rd_addr == DONE_IDX) begin
                        Req_done <= Rd_en;
                    end
                    if (Rd_addr == LAST_IDX) begin
                        Rd_en   <= '0;
                        Rd_addr <= '0;
                        frame_ctr[win_q] <= frame_ctr[win_q] + CTR_W'(1);
                        gap_cnt <= '0;
                        if (FRAME_GAP == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        Rd_addr <= Rd_addr + 5'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'(FRAME_GAP - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // win_q only changes in GRANT, which is always after the last
    // sample of the previous frame has left the output register.
    always_comb begin
        mux_i = Rd_data_i[win_q*DATA_WIDTH +: DATA_WIDTH];
        mux_q = Rd_data_q[win_q*DATA_WIDTH +: DATA_WIDTH];
    end

    // Stage 1 matches the RAM latency; stage 2 is the output register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            v1             <= 1'b0;
            idx1           <= '0;
            last1          <= 1'b0;
            Output_control <= '0;
            Output_i       <= '0;
            Output_q       <= '0;
            Frame_count    <= '0;
        end else begin
            v1    <= |Rd_en;
            idx1  <= (|Rd_en) ? Rd_addr : 5'd0;
            last1 <= (|Rd_en) && (Rd_addr == LAST_IDX);
            if (v1) begin
                Output_control.valid      <= 1'b1;
                Output_control.data_index <= idx1;
                Output_control.last       <= last1;
                Output_control.reverse    <= rev_q;
                Output_control.tag        <= tag_q;
                Output_i                  <= $signed(mux_i);
                Output_q                  <= $signed(mux_q);
            end else begin
                Output_control <= '0;
                Output_i       <= '0;
                Output_q       <= '0;
            end
            if (v1 && last1) begin
                Frame_count <= Frame_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/fft_32_frame_scheduler.md
# fft_32_frame_scheduler

Shares a single `fft_32` instance between `NUM_REQUESTERS` channel frame buffers. Each requester holds complete 32-sample frames in a RAM with 1-cycle read latency. The scheduler arbitrates between requesters one whole frame at a time. It reads the granted frame out sample-by-sample and drives `fft_32`'s `Input_control`/`Input_i`/`Input_q` with the correct `data_index`, `last`, `reverse` and `tag`, so that output frames can be routed back to their owning channel by tag.

## Interface
Parameters:
- `NUM_REQUESTERS`, 4: number of requesters; power of two, 2..16.
- `DATA_WIDTH`, 16: sample I/Q width; equals the FFT `INPUT_DATA_WIDTH`.
- `FRAME_GAP`, 0: idle cycles inserted between consecutive frames; range 0..255.

Ports:
- `Clk`  in  1  clock; single clock domain.
- `Rst`  in  1  asynchronous, active-high reset.
- `Req_ready`  in  `NUM_REQUESTERS`  level; bit n=1 means a complete frame is waiting in buffer n.
- `Req_reverse`  in  `NUM_REQUESTERS`  per-requester forward(0)/reverse(1) transform select; sampled at grant.
- `Req_done`  out  `NUM_REQUESTERS`  one-cycle pulse; buffer n's frame has been fully read.
- `Rd_addr`  out  5  sample address into the granted buffer.
- `Rd_en`  out  `NUM_REQUESTERS`  one-hot read enable; only the granted requester's bit is set.
- `Rd_data_i`  in  `NUM_REQUESTERS`×`DATA_WIDTH`  per-buffer read data, I component; valid 1 cycle after `Rd_en`.
- `Rd_data_q`  in  `NUM_REQUESTERS`×`DATA_WIDTH`  per-buffer read data, Q component; same timing as `Rd_data_i`.
- `Output_control`  out  `fft32_control_t`  to `fft_32` `Input_control`.
- `Output_i`  out  `DATA_WIDTH`  signed; to `fft_32` `Input_i`.
- `Output_q`  out  `DATA_WIDTH`  signed; to `fft_32` `Input_q`.
- `Frame_count`  out  32  total frames issued; wraps.

## Operation
- State machine has four states: IDLE, GRANT, READ, GAP.
  - IDLE: moves to GRANT when any `Req_ready` bit is set.
  - GRANT (1 cycle): the arbiter picks a winner and latches `Req_reverse[winner]`. The tag becomes {winner id in the upper `log2(NUM_REQUESTERS)` bits, the winner's 8−log2(N)-bit frame counter in the low bits}.
  - READ (32 cycles): `Rd_addr` counts 0..31 and `Rd_en[winner]`=1 every cycle. `Req_done[winner]` pulses in the cycle `Rd_addr`=31, and the winner's frame counter increments (wrapping).
  - GAP: lasts `FRAME_GAP` cycles, then returns to IDLE. The GAP state is skipped when `FRAME_GAP`=0; IDLE is entered directly and moves to GRANT on the next cycle if any request is pending.
- Arbitration is round-robin. The search starts at (last winner+1) mod N. The pointer resets to N−1, so requester 0 wins first.
- Requester contract: deassert `Req_ready[n]` on the edge that samples `Req_done[n]`. GRANT is at least one cycle after `Req_done`, so a stale ready bit is never sampled.
- The data path muxes `Rd_data[winner]` using the winner register. Control fields are delayed 1 cycle to align with RAM latency, then registered once more onto the outputs.
- `Output_control`:
  - `valid`=1 exactly 32 cycles per frame.
  - `data_index`=0..31.
  - `last`=1 on index 31 only.
  - `reverse` and `tag` are constant within a frame.
- When `valid`=0, all other output fields are 0.
- Requests that change during READ do not affect the frame in progress.

## Timing
- Reset value of every output is 0, including `Output_control` (all fields), `Rd_en`, `Rd_addr`, `Req_done` and `Frame_count`. All internal counters, frame counters and the round-robin pointer reset immediately, asynchronously.
- Latency:
  - Cycle with `Req_ready` seen in IDLE = t.
  - GRANT = t+1.
  - First `Rd_en` = t+2.
  - First `Output_control.valid` = t+4 (1 cycle RAM + 1 output register).
- Back-to-back frames (`FRAME_GAP`=0, continuous requests): the period is 34 cycles (32 READ + IDLE + GRANT), leaving 2 invalid cycles between frames.
- Reset during a frame: output `valid` drops asynchronously and the partial frame is abandoned with no `Req_done`. After `Rst` deasserts, the same requester's frame is re-read from index 0 if its ready bit is still set.
- `Frame_count` increments in the cycle `last` is output.

## Configuration
- `FFT_32_FRAME_SCHEDULER_PRIORITY_EN`:
  - Defined: requester 0 has strict priority over all others in GRANT. Round-robin applies among requesters 1..N−1 only, and requester 0 can starve the others.
  - Undefined: pure round-robin across all N requesters; every requester is served within N frames.

## Structure
- `dsp_pkg` holds:
  - `fft32_control_t` (existing).
  - New `fft32_sched_state_t` enum (IDLE, GRANT, READ, GAP).
  - `FFT32_FRAME_LENGTH = 32`.
  - `FFT32_TAG_WIDTH = 8`.
- One sub-module, `fft_32_rr_arbiter`: combinational request vector → winner, with a registered pointer update on the grant strobe. The priority macro is handled inside this sub-module.

## Test plan
- Requester 0 ready with a buffer holding i=k, q=−k → 32 valid outputs with index 0..31, data k/−k, `last` on 31, `tag`=0x00, `Req_done[0]` pulse, `Frame_count`=1.
- All 4 requesters ready at once, `FRAME_GAP`=4 → grant order 0,1,2,3; tags 0x00,0x40,0x80,0xC0; exactly 4+2 invalid cycles between frames.
- Requesters 1 and 2 ready continuously → strict alternation 1,2,1,2; per-frame `reverse` follows `Req_reverse` sampled at grant.
- 65 frames from requester 1 → tags 0x40..0x7F then wrap to 0x40; `Frame_count`=65.
- Assert `Rst` at index 10 → `valid`=0 immediately, no `Req_done`; after release, the frame restarts at index 0.
- With `FFT_32_FRAME_SCHEDULER_PRIORITY_EN` defined and requesters 0 and 3 always ready → only requester 0 is granted. With the macro undefined → 0,3,0,3.
